// File: rtl/output_requant_writer_pkg.sv
// Shared accelerator definitions: datapath modes, writeback FSM states,
// output SRAM depth and INT8 saturation bounds.
package output_requant_writer_pkg;

  typedef enum logic [1:0] {
    MODE_CONV   = 2'd0,
    MODE_DWCONV = 2'd1,
    MODE_FC     = 2'd2,
    MODE_POOL   = 2'd3
  } acc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // 6 blocks x 32768 words x 16 bit
  localparam int unsigned OUT_WORDS = 32'd196608;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

endpackage

// File: rtl/output_requant_writer_requant_unit.sv
// Two-stage requantiser: bias add, then rounded arithmetic shift with INT8 saturation.
// Define OUT_RELU_EN to clamp the low bound to 0 instead of -128.
module requant_unit
  import output_requant_writer_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [15:0]      bias_i,
  input  logic [4:0]       shift_i,
  output logic             s1_valid_o,
  output logic             valid_o,
  output logic [7:0]       q_o
);

  localparam int unsigned SW = ACC_W + 1;
  localparam int unsigned RW = ACC_W + 2;

`ifdef OUT_RELU_EN
  localparam int Q_LO = 0;
`else
  localparam int Q_LO = INT8_MIN;
`endif

  logic                 s1_v_q, v2_q;
  logic signed [SW-1:0] sum_d, sum_q;
  logic signed [RW-1:0] rnd, shd;
  logic [7:0]           q_d, q_q;

  // One extra bit over the sum keeps the rounding add from overflowing.
  always_comb begin
    sum_d = SW'($signed(acc_i)) + SW'($signed(bias_i));
    rnd   = RW'(sum_q);
    if (shift_i != 5'd0) rnd = rnd + (RW'(1) << (shift_i - 5'd1));
    shd = rnd >>> shift_i;
    if (shd > RW'(INT8_MAX))  q_d = 8'(INT8_MAX);
    else if (shd < RW'(Q_LO)) q_d = 8'(Q_LO);
    else                      q_d = shd[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      q_q    <= '0;
    end else begin
      s1_v_q <= valid_i;
      v2_q   <= s1_v_q;
      if (valid_i) sum_q <= sum_d;
      if (s1_v_q)  q_q   <= q_d;
    end
  end

  assign s1_valid_o = s1_v_q;
  assign valid_o    = v2_q;
  assign q_o        = q_q;

endmodule

// File: rtl/output_requant_writer.sv
// Layer writeback: accepts accumulator results, requantises to INT8 and writes
// sign-extended 16-bit words to the output SRAM. Optional macro: OUT_RELU_EN.
module output_requant_writer #(
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_WORDS = output_requant_writer_pkg::OUT_WORDS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [17:0]      num_words_i,
  input  logic [17:0]      base_addr_i,
  input  logic [4:0]       shift_i,
  input  logic             acc_valid_i,
  input  logic [ACC_W-1:0] acc_data_i,
  input  logic [15:0]      bias_i,
  output logic             acc_ready_o,
  output logic             sram_cs_o,
  output logic             sram_we_o,
  output logic [17:0]      sram_addr_o,
  output logic [15:0]      sram_data_o,
  output logic             busy_o,
  output logic             finish_o
);
  import output_requant_writer_pkg::*;

  localparam logic [17:0] LAST_ADDR = 18'(OUT_WORDS - 1);

  wr_state_e   state_q;
  logic [17:0] num_q, cnt_q, addr_q, base_norm;
  logic [4:0]  shift_q;
  logic        busy_q, finish_q;
  logic        xfer, wr_v, s1_v;
  logic [7:0]  wr_q;

  assign acc_ready_o = (state_q == ST_RUN) && (cnt_q < num_q);
  assign xfer        = acc_valid_i && acc_ready_o;
  assign base_norm   = ({14'd0, base_addr_i} >= OUT_WORDS) ?
                       18'({14'd0, base_addr_i} - OUT_WORDS) : base_addr_i;

  requant_unit #(.ACC_W(ACC_W)) u_requant (
    .clk       (clk),
    .rstn      (rstn),
    .valid_i   (xfer),
    .acc_i     (acc_data_i),
    .bias_i    (bias_i),
    .shift_i   (shift_q),
    .s1_valid_o(s1_v),
    .valid_o   (wr_v),
    .q_o       (wr_q)
  );

  // Results leave the pipeline in acceptance order, so a running address suffices.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (wr_v) addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 18'd1;
      unique case (state_q)
        ST_IDLE: if (start_i) begin
          num_q   <= num_words_i;
          shift_q <= shift_i;
          cnt_q   <= '0;
          addr_q  <= base_norm;
          if (num_words_i == '0) begin
            state_q  <= ST_DONE;
            finish_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: if (xfer) begin
          cnt_q <= cnt_q + 18'd1;
          if (cnt_q + 18'd1 == num_q) state_q <= ST_DRAIN;
        end
        // Stage 1 empty means the last word writes this cycle.
        ST_DRAIN: if (!s1_v) begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          finish_q <= 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sram_cs_o   = wr_v;
  assign sram_we_o   = wr_v;
  assign sram_data_o = wr_v ? {{8{wr_q[7]}}, wr_q} : '0;
  assign sram_addr_o = wr_v ? addr_q : '0;
  assign busy_o      = busy_q;
  assign finish_o    = finish_q;

endmodule

// File: tb/tb_output_requant_writer.sv
// Self-checking bench for output_requant_writer (honours OUT_RELU_EN if defined).
module tb_output_requant_writer;

  localparam int unsigned OW = 196608;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [17:0] num_words_i, base_addr_i;
  logic [4:0]  shift_i;
  logic        acc_valid_i;
  logic [31:0] acc_data_i;
  logic [15:0] bias_i;
  logic        acc_ready_o, sram_cs_o, sram_we_o, busy_o, finish_o;
  logic [17:0] sram_addr_o;
  logic [15:0] sram_data_o;

  output_requant_writer #(.ACC_W(32), .OUT_WORDS(OW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .num_words_i(num_words_i),
    .base_addr_i(base_addr_i), .shift_i(shift_i), .acc_valid_i(acc_valid_i),
    .acc_data_i(acc_data_i), .bias_i(bias_i), .acc_ready_o(acc_ready_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o), .busy_o(busy_o), .finish_o(finish_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int fin_cnt = 0, fin_cyc = 0;
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], acc_cyc_q[$];
  int stim_acc[64], stim_bias[64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic straight from the requant rules.
  function automatic logic [15:0] ref_word(input int acc, input int bias, input int sh);
    longint s, lo;
    s = longint'(acc) + longint'(bias);
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >>> sh;
`ifdef OUT_RELU_EN
    lo = 0;
`else
    lo = -128;
`endif
    if (s > 127) s = 127;
    if (s < lo) s = lo;
    return 16'(s);
  endfunction

  always @(negedge clk) begin
    if (sram_cs_o) begin
      wr_addr_q.push_back(int'(sram_addr_o));
      wr_data_q.push_back(int'(sram_data_o));
      wr_cyc_q.push_back(cyc);
      chk("we_with_cs", longint'(sram_we_o), 1);
    end else begin
      chk("idle_data", longint'(sram_data_o), 0);
      chk("idle_we", longint'(sram_we_o), 0);
    end
    if (finish_o) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
  end

  task automatic clear_log();
    @(posedge clk);
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); acc_cyc_q.delete();
    fin_cnt = 0;
  endtask

  task automatic pulse_start(input int num, input int base, input int sh);
    @(negedge clk);
    start_i = 1'b1; num_words_i = 18'(num); base_addr_i = 18'(base); shift_i = 5'(sh);
    @(negedge clk);
    start_i = 1'b0; num_words_i = 18'($urandom); base_addr_i = 18'($urandom); shift_i = 5'($urandom);
  endtask

  task automatic run_layer(input int num, input int base, input int sh, input int prob,
                           input bit mid_start);
    int i, budget, n;
    bit v;
    clear_log();
    pulse_start(num, base, sh);
    i = 0; budget = 0;
    while (i < num && budget < 2000) begin
      v = ($urandom_range(0, 99) < prob);
      acc_valid_i = v;
      acc_data_i  = stim_acc[i];
      bias_i      = 16'(stim_bias[i]);
      start_i     = mid_start && (i == 1);
      if (v && acc_ready_o) begin
        acc_cyc_q.push_back(cyc);
        i++;
      end
      budget++;
      @(negedge clk);
    end
    acc_valid_i = 1'b0; start_i = 1'b0;
    if (i < num) chk("feed_timeout", i, num);
    budget = 0;
    while (fin_cnt == 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    chk("write_count", wr_addr_q.size(), num);
    n = (wr_addr_q.size() < num) ? wr_addr_q.size() : num;
    for (int k = 0; k < n; k++) begin
      chk("wr_addr", wr_addr_q[k], longint'((longint'(base) + k) % OW));
      chk("wr_data", wr_data_q[k], longint'(ref_word(stim_acc[k], stim_bias[k], sh)));
      if (k < acc_cyc_q.size()) chk("wr_latency", wr_cyc_q[k] - acc_cyc_q[k], 2);
    end
    chk("finish_count", fin_cnt, 1);
    if (n > 0 && fin_cnt > 0) chk("finish_after_last_wr", fin_cyc, wr_cyc_q[n-1] + 1);
    chk("busy_after", longint'(busy_o), 0);
  endtask

  typedef struct {
    int          acc;
    int          bias;
    int          sh;
    logic [15:0] exp_s;
    logic [15:0] exp_r;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int n_snap, idx, budget;
    logic [15:0] basic_exp[4];

    tbl[0] = '{100,          0,      4, 16'h0006, 16'h0006};
    tbl[1] = '{-100,         0,      4, 16'hFFFA, 16'h0000};
    tbl[2] = '{7,            1,      1, 16'h0004, 16'h0004};
    tbl[3] = '{-3,           0,      0, 16'hFFFD, 16'h0000};
    tbl[4] = '{-500,         0,      2, 16'hFF83, 16'h0000};
    tbl[5] = '{32'h7FFFFFFF, 32767,  0, 16'h007F, 16'h007F};
    tbl[6] = '{32'h80000000, -32768, 31, 16'hFFFF, 16'h0000};
    tbl[7] = '{255,          0,      1, 16'h007F, 16'h007F};
    tbl[8] = '{-257,         0,      1, 16'hFF80, 16'h0000};
    tbl[9] = '{-259,         0,      1, 16'hFF80, 16'h0000};

    rstn = 1'b0; start_i = 1'b0; num_words_i = '0; base_addr_i = '0; shift_i = '0;
    acc_valid_i = 1'b0; acc_data_i = '0; bias_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", longint'(acc_ready_o), 0);
    chk("rst_cs", longint'(sram_cs_o), 0);
    chk("rst_addr", longint'(sram_addr_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_finish", longint'(finish_o), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors, one single-word layer each
    for (int t = 0; t < 10; t++) begin
      stim_acc[0] = tbl[t].acc; stim_bias[0] = tbl[t].bias;
      run_layer(1, t * 3, tbl[t].sh, 100, 1'b0);
`ifdef OUT_RELU_EN
      if (wr_data_q.size() > 0) chk($sformatf("tbl%0d_data", t), wr_data_q[0], longint'(tbl[t].exp_r));
`else
      if (wr_data_q.size() > 0) chk($sformatf("tbl%0d_data", t), wr_data_q[0], longint'(tbl[t].exp_s));
`endif
    end

    // Basic 4-word layer
    stim_acc[0] = 100; stim_acc[1] = -100; stim_acc[2] = 5000; stim_acc[3] = -5000;
    for (int k = 0; k < 4; k++) stim_bias[k] = 0;
`ifdef OUT_RELU_EN
    basic_exp = '{16'h0006, 16'h0000, 16'h007F, 16'h0000};
`else
    basic_exp = '{16'h0006, 16'hFFFA, 16'h007F, 16'hFF80};
`endif
    run_layer(4, 0, 4, 100, 1'b0);
    for (int k = 0; k < 4; k++)
      if (k < wr_data_q.size()) begin
        chk("basic_data", wr_data_q[k], longint'(basic_exp[k]));
        chk("basic_addr", wr_addr_q[k], k);
      end

    // Bubbles and wrap
    for (int k = 0; k < 3; k++) begin stim_acc[k] = k * 40 - 30; stim_bias[k] = 3; end
    run_layer(3, 196606, 2, 50, 1'b0);
    if (wr_addr_q.size() == 3) chk("wrap_addr2", wr_addr_q[2], 0);
    run_layer(2, 196607, 0, 60, 1'b0);

    // Zero-length layer
    clear_log();
    @(negedge clk);
    start_i = 1'b1; num_words_i = '0; base_addr_i = 18'd5; shift_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    chk("zero_finish_next", longint'(finish_o), 1);
    repeat (5) @(negedge clk);
    chk("zero_finish_once", fin_cnt, 1);
    chk("zero_no_writes", wr_addr_q.size(), 0);

    // start_i during RUN ignored
    for (int k = 0; k < 6; k++) begin stim_acc[k] = k * 17 - 50; stim_bias[k] = -k; end
    run_layer(6, 1000, 1, 70, 1'b1);

    // Reset abort after two writes
    for (int k = 0; k < 8; k++) begin stim_acc[k] = k + 1; stim_bias[k] = 0; end
    clear_log();
    pulse_start(8, 100, 0);
    idx = 0; budget = 0;
    while (wr_addr_q.size() < 2 && budget < 50) begin
      acc_valid_i = 1'b1; acc_data_i = stim_acc[idx]; bias_i = '0;
      if (acc_ready_o) idx++;
      budget++;
      @(negedge clk);
    end
    chk("abort_reached_two", wr_addr_q.size() >= 2, 1);
    rstn = 1'b0; acc_valid_i = 1'b0;
    #1;
    chk("abort_cs", longint'(sram_cs_o), 0);
    chk("abort_we", longint'(sram_we_o), 0);
    chk("abort_data", longint'(sram_data_o), 0);
    chk("abort_addr", longint'(sram_addr_o), 0);
    chk("abort_busy", longint'(busy_o), 0);
    chk("abort_ready", longint'(acc_ready_o), 0);
    n_snap = wr_addr_q.size();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_more_wr", wr_addr_q.size(), n_snap);
    chk("abort_no_finish", fin_cnt, 0);
    if (wr_data_q.size() > 0) chk("abort_first_data", wr_data_q[0], 1);

    // Randomised layers against the reference model
    for (int r = 0; r < 8; r++) begin
      int num, base, sh;
      num  = $urandom_range(1, 12);
      base = (r % 3 == 0) ? int'(OW) - $urandom_range(1, 6) : $urandom_range(0, 262143);
      sh   = $urandom_range(0, 31);
      for (int k = 0; k < num; k++) begin
        stim_acc[k]  = int'($urandom) >>> $urandom_range(0, 28);
        stim_bias[k] = $urandom_range(0, 65535) - 32768;
      end
      run_layer(num, base, sh, $urandom_range(40, 100), r == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_requant_writer.md
OUTPUT_REQUANT_WRITER -- requirements
Module: output_requant_writer

Interface
REQ-001 The block SHALL have parameter ACC_W, default 32, meaning the signed accumulator width.
REQ-002 The block SHALL have parameter OUT_WORDS, default 196608, meaning the output SRAM depth: 6 blocks x 32768 words x 16 bit.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rstn, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port start_i, input, 1, a one-cycle pulse that launches a layer writeback.
REQ-006 The block SHALL have port num_words_i, input, 18, the number of results to write; sampled on start_i.
REQ-007 The block SHALL have port base_addr_i, input, 18, the first output word address; sampled on start_i.
REQ-008 The block SHALL have port shift_i, input, 5, the requant right-shift amount; sampled on start_i.
REQ-009 The block SHALL have port acc_valid_i, input, 1, meaning the upstream result is valid.
REQ-010 The block SHALL have port acc_data_i, input, ACC_W, the signed accumulator value.
REQ-011 The block SHALL have port bias_i, input, 16, the signed bias paired with acc_data_i.
REQ-012 The block SHALL have port acc_ready_o, output, 1, which accepts the upstream result.
REQ-013 The block SHALL have ports sram_cs_o, sram_we_o, sram_addr_o[17:0] and sram_data_o[15:0], all outputs, forming the output SRAM write port.
REQ-014 The block SHALL have ports busy_o and finish_o, outputs, 1 bit each, meaning layer active and one-cycle done pulse.

Function
REQ-015 The FSM SHALL use states IDLE, RUN, DRAIN and DONE: IDLE goes to RUN on start_i; RUN goes to DRAIN after the num_words_i-th acceptance; DRAIN goes to DONE when the pipeline is empty; DONE goes to IDLE after one cycle.
REQ-016 acc_ready_o SHALL be 1 only in RUN with accepted count < num_words; a transfer occurs when acc_valid_i and acc_ready_o are both 1.
REQ-017 Stage 1, registered, SHALL compute sum = acc_data_i + sign-extended bias_i at ACC_W+1 bits, with no overflow.
REQ-018 Stage 2, registered, SHALL compute q = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, then saturate q to [-128,127].
REQ-019 The SRAM write SHALL occur in the cycle after stage 2, so latency from acceptance to sram_cs_o is 2 cycles, with throughput of 1 word per cycle.
REQ-020 A write SHALL drive sram_cs_o=1, sram_we_o=1, sram_data_o={8{q[7]},q[7:0]} and sram_addr_o=(base+index) mod OUT_WORDS.
REQ-021 sram_cs_o, sram_we_o and sram_data_o SHALL be 0 in every non-write cycle.
REQ-022 finish_o SHALL pulse exactly once in DONE, which is the cycle after the last write.
REQ-023 busy_o SHALL be 1 in RUN and DRAIN.
REQ-024 If num_words_i=0, the FSM SHALL go IDLE→DONE directly, with finish_o one cycle after start_i and no writes.
REQ-025 start_i SHALL be ignored in every state except IDLE.
REQ-026 Address wrap-around SHALL be handled as follows: base 196607 followed by a second word SHALL write address 0.
REQ-027 Upstream bubbles, where acc_valid_i=0 in RUN, SHALL insert idle SRAM cycles with no loss or reordering of results.

Reset
REQ-028 While rstn=0, the block SHALL force state to IDLE, clear all outputs, clear the pipeline valid bits, and clear the counters asynchronously.
REQ-029 Reset asserted mid-layer SHALL abort the layer with no further writes and no finish_o pulse.

Configuration
REQ-030 When macro OUT_RELU_EN is defined, the block SHALL clamp q to [0,127] so negative results write 0x0000.
REQ-031 When OUT_RELU_EN is undefined, the block SHALL use the signed range [-128,127] per REQ-018.

Structure
REQ-032 The FSM state enum, OUT_WORDS, and the INT8 min/max constants SHALL reside in the shared accelerator package, next to the existing mode definitions.
REQ-033 Stages 1 and 2 SHALL be a single sub-module, requant_unit, which is purely pipelined with a valid-in/valid-out interface and no FSM.

Verification
REQ-034 Scenario (basic): num=4, base=0, shift=4, acc={100,-100,5000,-5000}, bias=0 -> writes at addr 0..3 of 0x0006, 0xFFFA, 0x007F, 0xFF80; finish_o pulses once.
REQ-035 Scenario (bias and rounding): acc=7, bias=1, shift=1 -> writes 0x0004; with shift=0, acc=-3, bias=0 -> writes 0xFFFD.
REQ-036 Scenario (bubbles and wrap): base=196606, num=3, acc_valid_i toggling -> writes at addresses 196606, 196607 and 0, in order.
REQ-037 Scenario (zero and restart): num=0 -> finish_o one cycle after start_i with no writes; start_i pulsed during RUN -> ignored.
REQ-038 Scenario (reset abort): rstn=0 after 2 of 8 words -> all outputs go to 0 immediately and no finish_o occurs; a following layer runs correctly.
REQ-039 Scenario (OUT_RELU_EN): acc=-500, bias=0, shift=2 -> writes 0x0000 with the macro defined, and 0xFF83 without it.
